// File: rtl/wide_addsub_pkg.sv
// Shared types and constants for the sequential wide adder/subtractor.
// FSM state encoding, slice geometry and operation codes live here.
package wide_addsub_pkg;

    localparam int SLICE_W = 16;
    localparam int NIB_W = 4;

    localparam logic MOD_ADD = 1'b0;
    localparam logic MOD_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wide_addsub_seq_slice.sv
// 16-bit adder slice with explicit carry-in/out, shared across all
// operand slices by the sequencer; carry-select over 4-bit ripple groups.
module addsub_slice16
    import wide_addsub_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    localparam int NNIB = SLICE_W / NIB_W;

    function automatic logic [NIB_W:0] ripple4(
        input logic [NIB_W-1:0] x,
        input logic [NIB_W-1:0] y,
        input logic             ci
    );
        logic [NIB_W:0] r;
        logic           cc;
        r  = '0;
        cc = ci;
        for (int i = 0; i < NIB_W; i++) begin
            r[i] = x[i] ^ y[i] ^ cc;
            cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
        end
        r[NIB_W] = cc;
        return r;
    endfunction

    // Both nibble results are formed up front; the incoming carry only selects.
    always_comb begin
        logic           c;
        logic [NIB_W:0] r0;
        logic [NIB_W:0] r1;
        sum = '0;
        c   = cin;
        r0  = '0;
        r1  = '0;
        for (int n = 0; n < NNIB; n++) begin
            r0 = ripple4(a[n*NIB_W +: NIB_W], b[n*NIB_W +: NIB_W], 1'b0);
            r1 = ripple4(a[n*NIB_W +: NIB_W], b[n*NIB_W +: NIB_W], 1'b1);
            sum[n*NIB_W +: NIB_W] = c ? r1[NIB_W-1:0] : r0[NIB_W-1:0];
            c = c ? r1[NIB_W] : r0[NIB_W];
        end
        cout = c;
    end

endmodule

// File: rtl/wide_addsub_seq.sv
// Sequential W-bit add/sub, one 16-bit slice per cycle, LSB slice first.
// Define WIDE_ADDSUB_SOVF_EN to add the signed-overflow output ovf_s.
module wide_addsub_seq
    import wide_addsub_pkg::*;
#(
    parameter  int NWORDS = 4,
    localparam int W      = SLICE_W * NWORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         mod,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         carry,
    output logic         zero
`ifdef WIDE_ADDSUB_SOVF_EN
    ,
    output logic         ovf_s
`endif
);

    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    state_t state_q;
    state_t state_d;
    logic   ld;
    logic   step;
    logic   last;

    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       y_q;
    logic [W-1:0]       y_nxt;
    logic               c_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic               zero_q;
    int                 base;

    logic [SLICE_W-1:0] s_a;
    logic [SLICE_W-1:0] s_b;
    logic [SLICE_W-1:0] s_sum;
    logic               s_cout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ld      = 1'b0;
        step    = 1'b0;
        last    = (idx_q == LAST_IDX);
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ld      = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    assign base = int'(idx_q) * SLICE_W;
    assign s_a  = a_q[base +: SLICE_W];
    assign s_b  = b_q[base +: SLICE_W];

    addsub_slice16 u_slice (
        .a    (s_a),
        .b    (s_b),
        .cin  (c_q),
        .sum  (s_sum),
        .cout (s_cout)
    );

    // Result with the current slice merged in, so flags see the full word.
    always_comb begin
        y_nxt = y_q;
        y_nxt[base +: SLICE_W] = s_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (ld) begin
            a_q   <= a;
            b_q   <= (mod == MOD_ADD) ? b : ~b;
            c_q   <= mod;
            idx_q <= '0;
        end else if (step) begin
            y_q   <= y_nxt;
            c_q   <= s_cout;
            idx_q <= idx_q + IDX_W'(1);
            if (last) begin
                carry_q <= s_cout;
                zero_q  <= (y_nxt == '0);
            end
        end
    end

    assign y     = y_q;
    assign carry = carry_q;
    assign zero  = zero_q;

`ifdef WIDE_ADDSUB_SOVF_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (step && last) begin
            ovf_q <= (a_q[W-1] == b_q[W-1]) && (y_nxt[W-1] != a_q[W-1]);
        end
    end

    assign ovf_s = ovf_q;
`endif

endmodule

// File: tb/tb_wide_addsub_seq.sv
// Directed self-checking bench for wide_addsub_seq (NWORDS=4, W=64).
// Signed-overflow checks are active when WIDE_ADDSUB_SOVF_EN is defined.
module tb_wide_addsub_seq;

    localparam int NWORDS = 4;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         mod = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] y;
    logic         carry;
    logic         zero;
`ifdef WIDE_ADDSUB_SOVF_EN
    logic         ovf_s;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wide_addsub_seq #(.NWORDS(NWORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mod       (mod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .carry     (carry),
        .zero      (zero)
`ifdef WIDE_ADDSUB_SOVF_EN
        ,
        .ovf_s     (ovf_s)
`endif
    );

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                            input logic tm, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        a = ta;
        b = tb_v;
        mod = tm;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || y !== 64'h0 || carry !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ov=%b y=%h c=%b z=%b expected 0/0/0/0",
                     out_valid, y, carry, zero);
        end
`ifdef WIDE_ADDSUB_SOVF_EN
        checks++;
        if (ovf_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b expected 0", ovf_s);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b ov=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_idle_out_ready();
        logic bad;
        bad = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
        end
        out_ready = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL idle_out_ready: got ov=%b rdy=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_add_wrap();
        int lat;
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL add_wrap_latency: got %0d expected 4", lat);
        end
        checks++;
        if (y !== 64'h0 || carry !== 1'b1 || zero !== 1'b1) begin
            errors++;
            $display("FAIL add_wrap: got y=%h c=%b z=%b expected 0/1/1", y, carry, zero);
        end
`ifdef WIDE_ADDSUB_SOVF_EN
        checks++;
        if (ovf_s !== 1'b0) begin
            errors++;
            $display("FAIL add_wrap_ovf: got %b expected 0", ovf_s);
        end
`endif
        release_result();
    endtask

    task automatic test_sub();
        int lat;
        start_op(64'd5, 64'd7, 1'b1, lat);
        checks++;
        if (lat !== 4 || y !== 64'hFFFF_FFFF_FFFF_FFFE || carry !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL sub_5_7: got lat=%0d y=%h c=%b z=%b expected 4/fffffffffffffffe/0/0",
                     lat, y, carry, zero);
        end
        release_result();
        start_op(64'd7, 64'd5, 1'b1, lat);
        checks++;
        if (y !== 64'd2 || carry !== 1'b1 || zero !== 1'b0) begin
            errors++;
            $display("FAIL sub_7_5: got y=%h c=%b z=%b expected 2/1/0", y, carry, zero);
        end
        release_result();
        start_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, lat);
        checks++;
        if (y !== 64'h0 || carry !== 1'b1 || zero !== 1'b1) begin
            errors++;
            $display("FAIL sub_equal: got y=%h c=%b z=%b expected 0/1/1", y, carry, zero);
        end
        release_result();
    endtask

    task automatic test_slice_carry();
        int lat;
        start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, lat);
        checks++;
        if (y !== 64'h0000_0000_0001_0000 || carry !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL slice_carry: got y=%h c=%b z=%b expected 10000/0/0", y, carry, zero);
        end
        release_result();
        start_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, lat);
        checks++;
        if (y !== 64'h1234_5678_9ABC_DF00 || carry !== 1'b0) begin
            errors++;
            $display("FAIL add_pattern: got y=%h c=%b expected 123456789abcdf00/0", y, carry);
        end
        release_result();
    endtask

    task automatic test_ovf();
        int lat;
        start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
        checks++;
        if (y !== 64'h8000_0000_0000_0000 || carry !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL ovf_result: got y=%h c=%b z=%b expected 8000000000000000/0/0",
                     y, carry, zero);
        end
`ifdef WIDE_ADDSUB_SOVF_EN
        checks++;
        if (ovf_s !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: got %b expected 1", ovf_s);
        end
`endif
        release_result();
    endtask

    task automatic test_backpressure();
        int   lat;
        logic bad;
        start_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, lat);
        @(negedge clk);
        a = 64'hFFFF_FFFF_FFFF_FFFF;
        b = 64'h1;
        in_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (y !== 64'h1234_5678_9ABC_DF00 || in_ready !== 1'b0 || out_valid !== 1'b1)
                bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL backpressure_hold: got y=%h rdy=%b ov=%b expected 123456789abcdf00/0/1",
                     y, in_ready, out_valid);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 64'h1234_5678_9ABC_DF00) begin
            errors++;
            $display("FAIL backpressure_release: got rdy=%b ov=%b y=%h expected 1/0/123456789abcdf00",
                     in_ready, out_valid, y);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_idle: got rdy=%b expected 1", in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        int   lat;
        logic seen;
        @(negedge clk);
        a = 64'h0000_0000_0000_FFFF;
        b = 64'h1;
        mod = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || y !== 64'h0 || carry !== 1'b0 || zero !== 1'b0
            || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrun_reset: got ov=%b y=%h c=%b z=%b rdy=%b expected 0/0/0/0/1",
                     out_valid, y, carry, zero, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midrun_discard: got ov=%b rdy=%b expected 0/1", out_valid, in_ready);
        end
        start_op(64'd7, 64'd5, 1'b1, lat);
        checks++;
        if (lat !== 4 || y !== 64'd2 || carry !== 1'b1) begin
            errors++;
            $display("FAIL midrun_next: got lat=%0d y=%h c=%b expected 4/2/1", lat, y, carry);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        a = 64'd3;
        b = 64'd5;
        mod = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 64'd10;
        b = 64'd3;
        mod = 1'b1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 4 || y !== 64'd8 || carry !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d y=%h c=%b expected 4/8/0", lat, y, carry);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: got rdy=%b ov=%b expected 1/0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got rdy=%b expected 0", in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 4 || y !== 64'd7 || carry !== 1'b1 || zero !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d y=%h c=%b z=%b expected 4/7/1/0",
                     lat, y, carry, zero);
        end
        release_result();
    endtask

    initial begin
        test_reset();
        test_idle_out_ready();
        test_add_wrap();
        test_sub();
        test_slice_carry();
        test_ovf();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wide_addsub_seq.md
WIDE_ADDSUB_SEQ -- requirements
Module: wide_addsub_seq

Interface
REQ-001 Parameter: NWORDS, 4, number of 16-bit slices; operand width W = 16*NWORDS.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 a  input  W  operand A.
REQ-007 b  input  W  operand B.
REQ-008 mod  input  1  0: A+B; 1: A-B.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 y  output  W  result, modulo 2^W.
REQ-012 carry  output  1  final carry-out; for subtraction, 1 means no borrow.
REQ-013 zero  output  1  y equals 0.
REQ-014 ovf_s  output  1  signed two's-complement overflow; present only with WIDE_ADDSUB_SOVF_EN.

Function
REQ-015 FSM states: IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 IDLE: when in_valid=1, the block SHALL capture a, b and mod, clear the slice index, go to RUN.
REQ-017 Captured B SHALL be stored inverted when mod=1; the initial carry SHALL equal mod.
REQ-018 RUN: each cycle the block SHALL add slice k (bits 16k+15:16k) with the stored carry, write the 16-bit sum into y[16k+15:16k], and register the slice carry-out as the next carry-in; order is LSB slice first.
REQ-019 After slice NWORDS-1 the block SHALL go to DONE; out_valid SHALL rise exactly NWORDS cycles after the accepting edge.
REQ-020 DONE: out_valid=1; y, carry, zero and ovf_s SHALL hold stable until out_ready=1.
REQ-021 The DONE to IDLE transition SHALL occur on the edge where out_ready=1; a new request SHALL NOT be accepted in that same cycle, which gives one idle cycle between results.
REQ-022 in_valid in RUN or DONE SHALL be ignored; operands SHALL NOT change mid-operation.
REQ-023 out_ready while out_valid=0 SHALL have no effect.
REQ-024 zero SHALL be computed over the full W-bit result and be valid whenever out_valid=1.
REQ-025 y SHALL be bit-exact with (a + (mod ? ~b : b) + mod) mod 2^W.

Reset
REQ-026 On rst=1 the FSM SHALL go to IDLE immediately, regardless of the current state.
REQ-027 Reset values: in_ready=1 once rst deasserts; out_valid=0, y=0, carry=0, zero=0, ovf_s=0.
REQ-028 Reset during RUN or DONE SHALL discard the operation; no out_valid SHALL be produced for it.

Configuration
REQ-029 Macro WIDE_ADDSUB_SOVF_EN.
REQ-030 When the macro is defined, the ovf_s port SHALL exist and equal (A[W-1]==B'[W-1]) && (y[W-1]!=A[W-1]), where B' is the stored, possibly inverted, B; it SHALL be evaluated on the last slice.
REQ-031 When the macro is undefined, the ovf_s port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Shared package wide_addsub_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE), the SLICE_W=16 constant, and the MOD_ADD=0/MOD_SUB=1 constants.
REQ-033 One sub-module, addsub_slice16, SHALL implement the 16-bit add with explicit carry-in and carry-out, built as a carry-select of two 4-bit ripple groups per nibble; it SHALL be instantiated once and time-multiplexed across slices.

Verification
REQ-034 mod=0, a=0xFFFF_FFFF_FFFF_FFFF, b=0x1 -> y=0, carry=1, zero=1, ovf_s=0, out_valid 4 cycles after accept.
REQ-035 mod=1, a=5, b=7 -> y=0xFFFF_FFFF_FFFF_FFFE, carry=0, zero=0; a=7, b=5 -> y=2, carry=1.
REQ-036 Macro defined, mod=0, a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> y=0x8000_0000_0000_0000, ovf_s=1, carry=0; carry across slice boundary a=0x0000_0000_0000_FFFF, b=1 -> y=0x1_0000.
REQ-037 Backpressure: hold out_ready=0 for 10 cycles in DONE -> y stable, in_ready=0, new in_valid ignored; release -> in_ready=1 one cycle later.
REQ-038 Assert rst in the 2nd RUN cycle -> out_valid stays 0, all outputs 0, in_ready=1 after release; the next request completes correctly.
